// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, opcodes and FSM encoding for alu_arbiter
//
// Purpose: common definitions imported by alu_arbiter and rr_arbiter.
//   ALU_CTL_W : width of the ALU result-mux select
//   ID_W      : width of requester ids and the round-robin pointer (up to 8 requesters)
//   CNT_W     : width of the EXEC cycle counter
//   alu_op_e  : opcodes, passed to the ALU unchanged as alu_ctl
//   state_e   : arbiter FSM states
package alu_pkg;

    localparam int ALU_CTL_W = 3;
    localparam int ID_W      = 3;
    localparam int CNT_W     = 3;

    typedef enum logic [ALU_CTL_W-1:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        XOR  = 3'd2,
        SLT  = 3'd3,
        AND  = 3'd4,
        NAND = 3'd5,
        NOR  = 3'd6,
        OR   = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner selection
//
// Purpose: picks the first asserted request found when searching upward from
// ptr, wrapping modulo N_REQ.
// Ports:
//   req   in  N_REQ  request vector
//   ptr   in  ID_W   index where the search starts (always < N_REQ)
//   grant out N_REQ  one-hot winner, all-zero when no request is asserted
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant
);

    logic found;

    // Outer loop walks search distance from ptr, inner loop finds the requester
    // at that distance; every bit index stays a constant loop variable.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req[j] && (j == ((int'(ptr) + k) % N_REQ))) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU among N_REQ requesters
//
// Purpose: grants one requester at a time, issues its registered operands and
// opcode to an external ALU, waits ALU_LATENCY cycles, captures the result and
// flags and presents them on a valid/ready response port.
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   req_valid/req_ready     per-requester handshake (req_ready is one-hot)
//   req_op/req_a/req_b      per-requester opcode and operands, packed by index
//   alu_a/alu_b/alu_ctl     registered operands and opcode to the ALU
//   alu_result/alu_flags    ALU outputs, flags = {carryout, overflow, zero}
//   rsp_valid/rsp_ready     response handshake
//   rsp_id/rsp_result/rsp_flags  owner and captured ALU outputs
//   busy                    high whenever the FSM is not IDLE
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 32,
    parameter int ALU_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*ALU_CTL_W-1:0] req_op,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [ALU_CTL_W-1:0]       alu_ctl,
    input  logic [WIDTH-1:0]           alu_result,
    input  logic [2:0]                 alu_flags,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [WIDTH-1:0]           rsp_result,
    output logic [2:0]                 rsp_flags,
    output logic                       busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LATENCY - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ID_W-1:0]        owner_q, owner_d;
    logic [WIDTH-1:0]       alu_a_q, alu_a_d;
    logic [WIDTH-1:0]       alu_b_q, alu_b_d;
    logic [ALU_CTL_W-1:0]   alu_ctl_q, alu_ctl_d;
    logic [WIDTH-1:0]       rsp_result_q, rsp_result_d;
    logic [2:0]             rsp_flags_q, rsp_flags_d;

    logic [N_REQ-1:0]       grant;
    logic                   grant_window;
    logic                   transfer;
    logic [ID_W-1:0]        win_idx;
    logic [WIDTH-1:0]       sel_a;
    logic [WIDTH-1:0]       sel_b;
    logic [ALU_CTL_W-1:0]   sel_op;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // A new grant is possible when idle, or while the current response is
    // being accepted so back-to-back operations lose no cycle.
    assign grant_window = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);

    // Gated by reset so req_ready drops the moment reset asserts, not at the next edge.
    assign req_ready = (grant_window && !reset) ? grant : '0;
    assign transfer  = |(req_valid & req_ready);

    // Winner's index and payload, picked from the packed request buses.
    always_comb begin
        win_idx = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_op  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                win_idx = ID_W'(i);
                sel_a   = req_a[WIDTH*i +: WIDTH];
                sel_b   = req_b[WIDTH*i +: WIDTH];
                sel_op  = req_op[ALU_CTL_W*i +: ALU_CTL_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctl_d    = alu_ctl_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // transfer can only be true inside a grant window, so it overrides the
        // IDLE hold and the RESP -> IDLE exit alike.
        if (transfer) begin
            alu_a_d   = sel_a;
            alu_b_d   = sel_b;
            alu_ctl_d = sel_op;
            owner_d   = win_idx;
            cnt_d     = '0;
            ptr_d     = (win_idx == ID_LAST) ? '0 : win_idx + ID_W'(1);
            state_d   = ST_EXEC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            owner_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctl_q    <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctl_q    <= alu_ctl_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctl    = alu_ctl_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = owner_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters (2..8).
REQ-002 Parameter: WIDTH, 32, operand/result width.
REQ-003 Parameter: ALU_LATENCY, 1, cycles from operand issue to result capture (1..7).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 Port: clk  in  1  sole clock, rising edge.
REQ-006 Port: reset  in  1  asynchronous active-high reset.
REQ-007 Port: req_valid  in  N_REQ  per-requester operation request.
REQ-008 Port: req_ready  out  N_REQ  one-hot grant; transfer on req_valid[i] & req_ready[i].
REQ-009 Port: req_op  in  N_REQ*3  per-requester ALU opcode, slice i = bits [3i+2:3i].
REQ-010 Port: req_a, req_b  in  N_REQ*WIDTH  per-requester operands, slice i = [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-011 Port: alu_a, alu_b  out  WIDTH  registered operands to ALU.
REQ-012 Port: alu_ctl  out  3  registered 8:1 result-mux select.
REQ-013 Port: alu_result  in  WIDTH  ALU mux output.
REQ-014 Port: alu_flags  in  3  {carryout, overflow, zero} from ALU.
REQ-015 Port: rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-016 Port: rsp_id  out  3  index of requester owning rsp_result.
REQ-017 Port: rsp_result  out  WIDTH; rsp_flags  out  3  captured ALU outputs.
REQ-018 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, EXEC, RESP.
REQ-020 Grant window SHALL be: state IDLE, or state RESP with rsp_ready high (back-to-back).
REQ-021 In a grant window req_ready SHALL be one-hot on the round-robin winner among asserted req_valid, all-zero otherwise; it is combinational from req_valid, state, pointer.
REQ-022 Round-robin: search starts at pointer; after a transfer from i, pointer SHALL become (i+1) mod N_REQ.
REQ-023 On transfer: alu_a, alu_b, alu_ctl SHALL load the winner's req_a, req_b, req_op (alu_ctl = opcode unchanged); owner id latched; cycle counter cleared; state -> EXEC.
REQ-024 alu_a, alu_b, alu_ctl SHALL hold stable from transfer until the next transfer.
REQ-025 EXEC SHALL last exactly ALU_LATENCY cycles; on the edge ending the last EXEC cycle rsp_result/rsp_flags capture alu_result/alu_flags, state -> RESP.
REQ-026 rsp_valid SHALL be high exactly in RESP; rsp_result, rsp_flags, rsp_id stable while rsp_valid & !rsp_ready.
REQ-027 RESP with rsp_ready: no transfer -> IDLE; transfer -> EXEC with new operands.
REQ-028 No grant SHALL occur in EXEC or in RESP without rsp_ready; requests wait, unlost.
REQ-029 Single requester with continuous req_valid and rsp_ready high SHALL see one transfer per ALU_LATENCY+1 cycles.
REQ-030 Counter width SHALL be 3 bits; no wrap beyond ALU_LATENCY-1.

Reset
REQ-031 Reset asserted SHALL immediately force: state IDLE, pointer 0, counter 0, req_ready 0, rsp_valid 0, busy 0, alu_a 0, alu_b 0, alu_ctl 0, rsp_result 0, rsp_flags 0, rsp_id 0.
REQ-032 Reset mid-EXEC or mid-RESP SHALL discard the operation; no response emitted after release.
REQ-033 First grant window SHALL be the first cycle after reset deasserts.

Structure
REQ-034 Shared package alu_pkg SHALL hold ALU_CTL_W=3 and opcodes ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7, plus state encoding.
REQ-035 One sub-module rr_arbiter (N_REQ requests, pointer in, one-hot grant out, combinational) SHALL implement REQ-021/REQ-022 selection.

Verification
REQ-036 Single request: req 2, ADD, a=5, b=7, LATENCY=1, rsp_ready=1 -> alu_ctl=0 next cycle, rsp_valid 2 cycles after transfer, rsp_result=12, rsp_id=2.
REQ-037 All four req_valid held after reset, LATENCY=1 -> grant order 0,1,2,3,0; transfers every 2 cycles.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles in RESP, req 1 pending -> rsp fields stable, req_ready[1]=0; rsp_ready=1 -> response accepted and req 1 granted same cycle.
REQ-039 LATENCY=3, SUB a=3, b=5 -> capture exactly 3 cycles after transfer, rsp_result=0xFFFFFFFE.
REQ-040 Reset pulse in EXEC -> all outputs zero asynchronously, no rsp_valid after release, next grant from requester 0.
REQ-041 Flag passthrough: alu_flags=3'b101 driven on capture edge -> rsp_flags=3'b101.
